// File: rtl/mac_pkg.sv
// Shared types and lane geometry for the MAC operand path.
package mac_pkg;

    localparam int unsigned A_W   = 24;
    localparam int unsigned C_W   = 16;
    localparam int unsigned IN_W  = 16;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned LW_W  = 5;

    typedef enum logic [1:0] {
        FP16 = 2'b00,
        FP8  = 2'b01,
        FP4  = 2'b10,
        INT4 = 2'b11
    } mode_e;

    function automatic logic [LW_W-1:0] lane_width(mode_e m);
        logic [LW_W-1:0] w;
        case (m)
            FP16:    w = LW_W'(16);
            FP8:     w = LW_W'(8);
            default: w = LW_W'(4);
        endcase
        return w;
    endfunction

    function automatic logic [CNT_W-1:0] lane_count(mode_e m);
        logic [CNT_W-1:0] n;
        case (m)
            FP16:    n = CNT_W'(1);
            FP8:     n = CNT_W'(3);
            default: n = CNT_W'(6);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mac_operand_packer_if.sv
// Beat input and packed-word output handshakes of the operand packer.
interface mac_operand_packer_if;

    logic                        in_valid;
    logic                        in_ready;
    logic [mac_pkg::IN_W-1:0]    in_a;
    logic [mac_pkg::IN_W-1:0]    in_b;
    logic [mac_pkg::C_W-1:0]     in_c;
    logic [1:0]                  in_mode;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [mac_pkg::A_W-1:0]     out_a;
    logic [mac_pkg::A_W-1:0]     out_b;
    logic [mac_pkg::C_W-1:0]     out_c;
    logic [1:0]                  out_mode;
    logic [mac_pkg::CNT_W-1:0]   out_lanes;

    modport master (
        output in_valid, in_a, in_b, in_c, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_c, out_mode, out_lanes
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_a, out_b, out_c, out_mode, out_lanes
    );

endinterface

// File: rtl/mac_lane_insert.sv
// Writes one element into lane idx of a packed word; lane 0 sits in the MSBs.
module mac_lane_insert
    import mac_pkg::*;
(
    input  logic [A_W-1:0]   word,
    input  logic [IN_W-1:0]  elem,
    input  mode_e            mode,
    input  logic [CNT_W-1:0] idx,
    output logic [A_W-1:0]   word_c
);

    logic [LW_W-1:0] w;
    logic [LW_W-1:0] sh;
    logic [A_W-1:0]  mask;

    always_comb begin
        w      = lane_width(mode);
        mask   = (A_W'(1) << w) - A_W'(1);
        sh     = '0;
        word_c = word;
        if (mode == FP16) begin
            word_c = A_W'(elem);
        end else begin
            sh     = LW_W'(A_W) - LW_W'(w * (LW_W'(idx) + LW_W'(1)));
            word_c = (word & ~(mask << sh)) | ((A_W'(elem) & mask) << sh);
        end
    end

endmodule

// File: rtl/mac_operand_packer.sv
// Packs per-beat operand pairs into A/B lane words with one held word of buffering.
module mac_operand_packer
    import mac_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mac_operand_packer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [A_W-1:0]   asm_a;
    logic [A_W-1:0]   asm_b;
    logic [C_W-1:0]   asm_c;
    mode_e            asm_mode;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [A_W-1:0]   out_a_q;
    logic [A_W-1:0]   out_b_q;
    logic [C_W-1:0]   out_c_q;
    mode_e            out_mode_q;
    logic [CNT_W-1:0] out_lanes_q;

    logic             beat_c;
    logic             first_c;
    mode_e            mode_c;
    logic [CNT_W-1:0] idx_c;
    logic [CNT_W-1:0] lanes_c;
    logic             done_c;
    logic             drain_c;
    logic             free_c;
    logic [C_W-1:0]   c_c;
    logic [A_W-1:0]   ins_a_c;
    logic [A_W-1:0]   ins_b_c;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_mode  = out_mode_q;
    assign bus.out_lanes = out_lanes_q;

    // Mode and C come from the bus on the first beat, from the assembly regs afterwards.
    always_comb begin
        beat_c  = bus.in_valid && in_ready_q;
        first_c = (state == IDLE);
        mode_c  = first_c ? mode_e'(bus.in_mode) : asm_mode;
        c_c     = first_c ? bus.in_c : asm_c;
        idx_c   = first_c ? '0 : cnt;
        lanes_c = idx_c + CNT_W'(1);
        done_c  = (lanes_c == lane_count(mode_c)) || bus.in_last;
        drain_c = out_valid_q && bus.out_ready;
        free_c  = !out_valid_q || bus.out_ready;
    end

    mac_lane_insert u_ins_a (
        .word   (asm_a),
        .elem   (bus.in_a),
        .mode   (mode_c),
        .idx    (idx_c),
        .word_c (ins_a_c)
    );

    mac_lane_insert u_ins_b (
        .word   (asm_b),
        .elem   (bus.in_b),
        .mode   (mode_c),
        .idx    (idx_c),
        .word_c (ins_b_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            asm_a       <= '0;
            asm_b       <= '0;
            asm_c       <= '0;
            asm_mode    <= FP16;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_mode_q  <= FP16;
            out_lanes_q <= '0;
        end else begin
            if (drain_c) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                IDLE, FILL: begin
                    if (beat_c) begin
                        if (done_c && free_c) begin
                            out_valid_q <= 1'b1;
                            out_a_q     <= ins_a_c;
                            out_b_q     <= ins_b_c;
                            out_c_q     <= c_c;
                            out_mode_q  <= mode_c;
                            out_lanes_q <= lanes_c;
                            asm_a       <= '0;
                            asm_b       <= '0;
                            asm_c       <= '0;
                            asm_mode    <= FP16;
                            cnt         <= '0;
                            state       <= IDLE;
                        end else begin
                            asm_a    <= ins_a_c;
                            asm_b    <= ins_b_c;
                            asm_c    <= c_c;
                            asm_mode <= mode_c;
                            cnt      <= lanes_c;
                            if (done_c) begin
                                state      <= HOLD;
                                in_ready_q <= 1'b0;
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                end
                HOLD: begin
                    // Held word replaces the draining one so out_valid stays high.
                    if (drain_c) begin
                        out_valid_q <= 1'b1;
                        out_a_q     <= asm_a;
                        out_b_q     <= asm_b;
                        out_c_q     <= asm_c;
                        out_mode_q  <= asm_mode;
                        out_lanes_q <= cnt;
                        asm_a       <= '0;
                        asm_b       <= '0;
                        asm_c       <= '0;
                        asm_mode    <= FP16;
                        cnt         <= '0;
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_packer.sv
// Scoreboard bench for mac_operand_packer: directed cases plus randomized beats.
module tb_mac_operand_packer;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [15:0] c;
        logic [1:0]  mode;
        logic [2:0]  lanes;
    } word_t;

    logic clk;
    logic rst_n;
    mac_operand_packer_if bus ();

    mac_operand_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    pop_cyc[$];
    word_t exp_q[$];
    word_t last_out;
    logic [15:0] pa[$];
    logic [15:0] pb[$];
    logic [1:0]  pmode;
    logic [15:0] pc;
    logic        rand_en = 1'b0;

    // Reference packing: lane k of width W is worth 2^(24-(k+1)W); 16-bit mode is plain.
    function automatic logic [23:0] pack(input logic [1:0] m, input logic [15:0] e[$]);
        longint acc;
        int     w;
        acc = 0;
        if (m == 2'd0) return 24'(e[0]);
        w = (m == 2'd1) ? 8 : 4;
        for (int k = 0; k < e.size(); k++) begin
            int ek;
            ek = int'(e[k]);
            acc += longint'(ek % (1 << w)) * (longint'(1) << (24 - (k + 1) * w));
        end
        return 24'(acc);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: in_ready check, output pop/compare, then model update from accepted beats.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            pa.delete();
            pb.delete();
        end else begin
            total++;
            if (bus.in_ready !== (exp_q.size() < 2)) begin
                bad++;
                $display("FAIL in_ready got=%b want=%b cyc=%0d", bus.in_ready, exp_q.size() < 2, cyc);
            end
            if (bus.out_valid && bus.out_ready) begin
                word_t got;
                got.a = bus.out_a; got.b = bus.out_b; got.c = bus.out_c;
                got.mode = bus.out_mode; got.lanes = bus.out_lanes;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word got a=%h b=%h lanes=%0d want none", got.a, got.b, got.lanes);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    if (got.a !== e.a || got.b !== e.b || got.c !== e.c ||
                        got.mode !== e.mode || got.lanes !== e.lanes) begin
                        bad++;
                        $display("FAIL word got a=%h b=%h c=%h m=%0d l=%0d want a=%h b=%h c=%h m=%0d l=%0d",
                                 got.a, got.b, got.c, got.mode, got.lanes,
                                 e.a, e.b, e.c, e.mode, e.lanes);
                    end
                end
                last_out = got;
                pop_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) begin
                int nl;
                if (pa.size() == 0) begin
                    pmode = bus.in_mode;
                    pc    = bus.in_c;
                end
                pa.push_back(bus.in_a);
                pb.push_back(bus.in_b);
                nl = (pmode == 2'd0) ? 1 : (pmode == 2'd1) ? 3 : 6;
                if (pa.size() == nl || bus.in_last) begin
                    word_t w;
                    w.a = pack(pmode, pa); w.b = pack(pmode, pb); w.c = pc;
                    w.mode = pmode; w.lanes = 3'(pa.size());
                    exp_q.push_back(w);
                    pa.delete();
                    pb.delete();
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic beat(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic last);
        int   n;
        logic took;
        n = 0;
        took = 1'b0;
        bus.in_valid = 1'b1; bus.in_mode = m; bus.in_a = a; bus.in_b = b;
        bus.in_c = c; bus.in_last = last;
        while (!took && n < 200) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) begin
            total++; bad++;
            $display("FAIL beat_timeout got=no_accept want=accept");
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int c0;
        int n;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;
        bus.in_mode = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_out_a",     32'(bus.out_a), 32'd0);
        chk("rst_out_b",     32'(bus.out_b), 32'd0);
        chk("rst_out_c",     32'(bus.out_c), 32'd0);
        chk("rst_out_mode",  32'(bus.out_mode), 32'd0);
        chk("rst_out_lanes", 32'(bus.out_lanes), 32'd0);
        @(posedge clk); #1;

        for (int i = 1; i <= 6; i++) beat(2'd3, 16'(i), 16'(7 - i), 16'h1234, 1'b0);
        wait_idle();
        chk("int4_a", 32'(last_out.a), 32'h123456);
        chk("int4_b", 32'(last_out.b), 32'h654321);
        chk("int4_lanes", 32'(last_out.lanes), 32'd6);

        beat(2'd1, 16'h00AB, 16'h0011, 16'h4120, 1'b0);
        beat(2'd1, 16'h00CD, 16'h0022, 16'hFFFF, 1'b0);
        beat(2'd1, 16'h00EF, 16'h0033, 16'hFFFF, 1'b0);
        wait_idle();
        chk("fp8_a", 32'(last_out.a), 32'hABCDEF);
        chk("fp8_c", 32'(last_out.c), 32'h4120);
        chk("fp8_mode", 32'(last_out.mode), 32'd1);
        chk("fp8_lanes", 32'(last_out.lanes), 32'd3);

        c0 = cyc;
        repeat (4) beat(2'd0, 16'h3F80, 16'h4000, 16'h3C00, 1'b0);
        chk("fp16_beat_cycles", 32'(cyc - c0), 32'd4);
        wait_idle();
        n = pop_cyc.size();
        chk("fp16_word_rate", 32'(pop_cyc[n-1] - pop_cyc[n-4]), 32'd3);
        chk("fp16_a", 32'(last_out.a), 32'h003F80);
        chk("fp16_b", 32'(last_out.b), 32'h004000);

        beat(2'd2, 16'h0007, 16'h0001, 16'h0000, 1'b0);
        beat(2'd2, 16'h0009, 16'h0002, 16'h0000, 1'b1);
        wait_idle();
        chk("fp4_last_a", 32'(last_out.a), 32'h790000);
        chk("fp4_last_lanes", 32'(last_out.lanes), 32'd2);
        beat(2'd2, 16'h0005, 16'h0003, 16'h0000, 1'b1);
        wait_idle();
        chk("fp4_restart_a", 32'(last_out.a), 32'h500000);

        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) beat(2'd1, 16'(8'h10 + i), 16'(8'h20 + i), 16'(i), 1'b0);
        @(negedge clk);
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_idle();
        n = pop_cyc.size();
        chk("hold_back_to_back", 32'(pop_cyc[n-1] - pop_cyc[n-2]), 32'd1);
        chk("hold_word2_a", 32'(last_out.a), 32'h131415);
        @(negedge clk);
        chk("hold_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) beat(2'd3, 16'h0001, 16'h0001, 16'h0000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) beat(2'd3, 16'h0008, 16'h0008, 16'h0000, 1'b0);
        wait_idle();
        chk("reset_fresh_a", 32'(last_out.a), 32'h888888);
        chk("reset_fresh_lanes", 32'(last_out.lanes), 32'd6);

        rand_en = 1'b1;
        repeat (400) beat(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                          16'($urandom), ($urandom_range(0, 9) == 0));
        rand_en = 1'b0;
        @(posedge clk); #2 bus.out_ready = 1'b1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
